// File: rtl/easy6502_pkg.sv
// Shared definitions for the easy6502 memory subsystem: default bus widths,
// video client limits and the client-index encoding used by the arbiter.
package easy6502_pkg;

   localparam int DEF_ADDR_WIDTH = 11;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int MAX_NUM_VID    = 4;

   // Wide enough to encode every video port plus the CPU slot
   localparam int CLIENT_IDX_W   = $clog2(MAX_NUM_VID + 1);

   // The CPU always takes the index just after the last video port
   function automatic int client_cpu(input int num_vid);
      return num_vid;
   endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Lowest-index-first one-hot priority encoder with an "any request" flag.
module arb_prio_enc #(
   parameter int N = 2
) (
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt,
   output logic         o_any
);

   logic w_found;

   // Walk upward from bit 0 and keep only the first asserted request
   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (i_req[k] && !w_found) begin
            o_gnt[k] = 1'b1;
            w_found  = 1'b1;
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/shared_ram_arbiter.sv
// Time-shares one single-port synchronous RAM between the CPU bus and
// NUM_VID video read ports. Video ports have fixed priority over the CPU.
// Optional starvation guard: define ARB_STARVE_GUARD_EN to force a CPU slot
// after MAX_STALL consecutive denied cycles.
module shared_ram_arbiter
   import easy6502_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_VID    = 2,
   parameter int MAX_STALL  = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_VID-1:0]            vid_req,
   input  logic [NUM_VID*ADDR_WIDTH-1:0] vid_addr,
   output logic [NUM_VID-1:0]            vid_gnt,
   output logic [NUM_VID-1:0]            vid_rvalid,
   output logic [DATA_WIDTH-1:0]         vid_rdata,
   input  logic [ADDR_WIDTH-1:0]         cpu_addr,
   input  logic                          cpu_we,
   input  logic [DATA_WIDTH-1:0]         cpu_wdata,
   output logic                          cpu_rdy,
   output logic [DATA_WIDTH-1:0]         cpu_rdata,
   output logic [ADDR_WIDTH-1:0]         ram_addr,
   output logic                          ram_we,
   output logic [DATA_WIDTH-1:0]         ram_wdata,
   input  logic [DATA_WIDTH-1:0]         ram_rdata
);

   logic [NUM_VID-1:0]      w_enc_gnt;
   logic                    w_vid_any;
   logic                    w_force;
   logic [CLIENT_IDX_W-1:0] w_gnt_idx;

   logic [NUM_VID-1:0]      r_vid_rvalid;
   logic                    r_last_cpu_rd;
   logic [DATA_WIDTH-1:0]   r_hold_q;

   arb_prio_enc #(
      .N (NUM_VID)
   ) u_prio (
      .i_req (vid_req),
      .o_gnt (w_enc_gnt),
      .o_any (w_vid_any)
   );

`ifdef ARB_STARVE_GUARD_EN
   logic [7:0] r_stall_cnt;

   assign w_force = (r_stall_cnt == MAX_STALL[7:0]);

   // Count consecutive CPU-denied cycles, saturating; any CPU slot clears it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= 8'd0;
      end else if (cpu_rdy) begin
         r_stall_cnt <= 8'd0;
      end else if (r_stall_cnt != MAX_STALL[7:0]) begin
         r_stall_cnt <= r_stall_cnt + 8'd1;
      end
   end
`else
   // Strict video priority; MAX_STALL has no effect in this build
   assign w_force = 1'b0 & (MAX_STALL == 0);
`endif

   // Grants are suppressed during reset and while the CPU slot is forced
   assign vid_gnt = (reset | w_force) ? '0 : w_enc_gnt;
   assign cpu_rdy = ~reset & (w_force | ~w_vid_any);

   // Encode the winning client; the CPU is the fallback index
   always_comb begin
      w_gnt_idx = CLIENT_IDX_W'(client_cpu(NUM_VID));
      for (int k = NUM_VID - 1; k >= 0; k--) begin
         if (vid_gnt[k]) w_gnt_idx = CLIENT_IDX_W'(k);
      end
   end

   // RAM address mux: the granted video port, otherwise the CPU
   always_comb begin
      ram_addr = cpu_addr;
      for (int k = 0; k < NUM_VID; k++) begin
         if (w_gnt_idx == CLIENT_IDX_W'(k)) ram_addr = vid_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Only a granted CPU cycle may write; ungranted writes simply wait
   assign ram_we    = cpu_rdy & cpu_we;
   assign ram_wdata = cpu_wdata;
   assign vid_rdata = ram_rdata;

   // Read-valid pipeline plus record of whether the CPU just issued a read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vid_rvalid  <= '0;
         r_last_cpu_rd <= 1'b0;
      end else begin
         r_vid_rvalid  <= vid_gnt;
         r_last_cpu_rd <= cpu_rdy & ~cpu_we;
      end
   end

   // Hold the CPU's own read data so video cycles cannot overwrite it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_q <= '0;
      end else if (r_last_cpu_rd) begin
         r_hold_q <= ram_rdata;
      end
   end

   assign vid_rvalid = r_vid_rvalid;
   assign cpu_rdata  = r_last_cpu_rd ? ram_rdata : r_hold_q;

endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Parametrised arbiter that time-shares one single-port synchronous RAM between the 6502 CPU bus and `NUM_VID` video read clients, such as the screen fetch and a future palette or sprite fetch. Video clients have fixed priority over the CPU. An optional starvation guard forces a CPU slot after a bounded stall. A read-data hold register ensures the CPU always sees the data for the access it actually completed, which fixes the stale-data hazard of simply gating RDY. It sits between `cpu`, the video renderers and `generic_ram` in the top level.

## Interface
Parameters:
- `ADDR_WIDTH`, default 11: RAM word address width.
- `DATA_WIDTH`, default 8: RAM data width.
- `NUM_VID`, default 2: number of video read ports, range 1..4. Port 0 has the highest priority.
- `MAX_STALL`, default 8: maximum consecutive CPU-denied cycles before a forced CPU slot. Used only with the guard macro; range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock (25 MHz domain).
- `reset`  in  1  asynchronous, active-high reset.
- `vid_req`  in  `NUM_VID`  per-port read request, level held until granted.
- `vid_addr`  in  `NUM_VID*ADDR_WIDTH`  per-port address; port k occupies bits [k*AW +: AW].
- `vid_gnt`  out  `NUM_VID`  one-hot grant, combinational, same cycle as the request.
- `vid_rvalid`  out  `NUM_VID`  registered one-hot flag: `vid_rdata` is valid for that port.
- `vid_rdata`  out  `DATA_WIDTH`  shared read-data bus, which is `ram_rdata` passed through.
- `cpu_addr`  in  `ADDR_WIDTH`  CPU address, presented every cycle.
- `cpu_we`  in  1  CPU write enable.
- `cpu_wdata`  in  `DATA_WIDTH`  CPU write data.
- `cpu_rdy`  out  1  combinational; high means the CPU access in this cycle is performed. Drives the CPU RDY pin.
- `cpu_rdata`  out  `DATA_WIDTH`  CPU read data, stable until the next completed CPU read.
- `ram_addr`  out  `ADDR_WIDTH`  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  `DATA_WIDTH`  RAM write data.
- `ram_rdata`  in  `DATA_WIDTH`  RAM read data, valid one cycle after the address.

## Operation
- The CPU is treated as requesting every cycle.
- Per-cycle grant is one-hot over {vid[0..NUM_VID-1], cpu}:
  - The lowest-index asserted `vid_req` wins.
  - The CPU wins if no video port is requesting, or if the guard forces a CPU slot.
- `ram_addr` is the granted client's address. `ram_we` = `cpu_rdy & cpu_we`. `ram_wdata` = `cpu_wdata`.
- When `vid_gnt` is not asserted and the CPU is not granted, `cpu_we` has no effect.
- A video port must hold `vid_addr` until it is granted.
- `last_cpu_rd` register: set to `cpu_rdy & ~cpu_we`.
- `cpu_rdata`:
  - equals `ram_rdata` when `last_cpu_rd`=1;
  - otherwise equals `hold_q`;
  - `hold_q` captures `ram_rdata` whenever `last_cpu_rd`=1.
- `vid_rvalid` is the registered `vid_gnt`.
- Two-cycle video-then-CPU and CPU-then-video interleaves must not corrupt the other side's data.
- While `reset` is high:
  - all grants, `cpu_rdy` and `ram_we` are 0;
  - `vid_rvalid`, `last_cpu_rd`, `hold_q` and the stall counter are 0.
- If reset asserts mid-access, the in-flight `rvalid` is dropped. There is no partial write, because the write is single-cycle.

## Timing
- Grant latency is 0 cycles: combinational from `vid_req`/reset state.
- Read latency is 1 cycle: `vid_rvalid[k]` and the new `cpu_rdata` appear in cycle N+1 after a grant in cycle N.
- Write latency is 0: the write commits at the `clk` edge ending the granted cycle.
- Back-to-back grants to the same or different clients are allowed every cycle. Throughput is 1 access per cycle.
- Simultaneous requests on all ports resolve by priority in a single cycle. No ungranted request is lost; it persists.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - an 8-bit `stall_cnt` increments on each cycle where the CPU is denied and saturates at `MAX_STALL`;
  - it clears on any CPU grant;
  - when `stall_cnt`==`MAX_STALL`, the CPU is granted over all video requests for one cycle.
- `ARB_STARVE_GUARD_EN` not defined: video has strict priority, the counter logic is absent, and the CPU may stall indefinitely.

## Structure
- Shared package `easy6502_pkg`:
  - default `ADDR_WIDTH`/`DATA_WIDTH`;
  - `MAX_NUM_VID`=4;
  - the client-index encoding `CLIENT_CPU` = `NUM_VID`.
- One sub-module, `arb_prio_enc`: a parametrised lowest-index-first one-hot priority encoder with an `any` output. It is used for the video request vector.
- The top-level arbiter holds the grant mux, the hold register, the `rvalid` pipeline and the guard counter.

## Test plan
- **Idle video:** `vid_req`=0. CPU writes 0x5A to 0x200, then reads 0x200 → `cpu_rdy`=1 every cycle, and `cpu_rdata`=0x5A one cycle after the read.
- **Stall hold:** CPU reads 0x010 (holding 0x33) in cycle N. `vid_req[0]` is asserted in cycles N+1..N+4 at address 0x300 (holding 0x77) → `cpu_rdy`=0 in N+1..N+4, and `cpu_rdata` stays 0x33 throughout. Port 0 gets `vid_rvalid[0]` with `vid_rdata`=0x77 in N+2..N+5.
- **Priority:** `vid_req`=2'b11 in the same cycle → `vid_gnt`=01 first, then 10 the next cycle. Each port gets `rvalid` with its own address data.
- **Blocked write:** CPU write of 0xFF to 0x100 during a video grant → RAM at 0x100 is unchanged. The write commits in the first cycle with `cpu_rdy`=1.
- **Guard (macro on, `MAX_STALL`=3):** `vid_req[0]` held continuously → the CPU is granted exactly every 4th cycle. With the macro off, `cpu_rdy` stays 0 for 20 cycles.
- **Reset mid-access:** assert `reset` in the cycle after a video grant → `vid_rvalid`=0 and `cpu_rdata`=0 immediately. Arbitration resumes normally after deassertion.
